// File: rtl/dfu_boot_pkg.sv
// Shared types and constants for the DFU boot-mode sequencer and its helpers.
package dfu_boot_pkg;

  typedef enum logic [2:0] {
    LOCK_WAIT = 3'd0,
    SAMPLE    = 3'd1,
    DFU       = 3'd2,
    DETACH    = 3'd3,
    HANDOFF   = 3'd4
  } boot_state_t;

  typedef enum logic [1:0] {
    MODE_WAIT    = 2'd0,
    MODE_SAMPLE  = 2'd1,
    MODE_DFU     = 2'd2,
    MODE_HANDOFF = 2'd3
  } boot_mode_t;

  localparam logic [7:0] DFU_ST_IDLE              = 8'h02;
  localparam logic [7:0] DFU_ST_MANIFEST_WAIT_RST = 8'h08;

  typedef struct packed {
    logic       dfu_reset;
    logic       usb_pull_en;
    logic       boot_req;
    boot_mode_t boot_mode;
  } boot_out_t;

  localparam boot_out_t BOOT_OUT_RESET = '{
    dfu_reset:   1'b1,
    usb_pull_en: 1'b0,
    boot_req:    1'b0,
    boot_mode:   MODE_WAIT
  };

  // Counter width able to hold n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/dfu_boot_ctrl_if.sv
// Control bundle between the boot sequencer (master) and the usb_dfu core / board logic (slave).
interface dfu_boot_ctrl_if;
  import dfu_boot_pkg::*;

  logic [7:0] dfu_state;
  logic       dfu_reset;
  logic       usb_pull_en;
  logic       boot_req;
  boot_mode_t boot_mode;

  modport master (
    input  dfu_state,
    output dfu_reset,
    output usb_pull_en,
    output boot_req,
    output boot_mode
  );

  modport slave (
    output dfu_state,
    input  dfu_reset,
    input  usb_pull_en,
    input  boot_req,
    input  boot_mode
  );

endinterface

// File: rtl/dfu_boot_ctrl_debounce.sv
// button_debounce: 2-flop synchroniser plus stable-level counter for any raw board button.
// btn_pressed flips only after the synced level disagrees with it for DEBOUNCE_CYCLES cycles in a row.
module button_debounce
  import dfu_boot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 48000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk_48mhz,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_pressed
);

  localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pressed_reg, pressed_next;
  logic             level;

  // Synchroniser idles at the released level so reset never looks like a press.
  assign level = sync_reg[1] ^ ACTIVE_LOW;

  always_comb begin
    cnt_next     = '0;
    pressed_next = pressed_reg;
    if (level != pressed_reg) begin
      if (cnt_reg == CNT_LAST) begin
        pressed_next = level;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      sync_reg    <= {2{ACTIVE_LOW}};
      cnt_reg     <= '0;
      pressed_reg <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[0], btn_raw};
      cnt_reg     <= cnt_next;
      pressed_reg <= pressed_next;
    end
  end

  assign btn_pressed = pressed_reg;

endmodule

// File: rtl/dfu_boot_ctrl.sv
// Boot-mode sequencer ahead of usb_dfu: PLL lock wait, button-select window, DFU, detach, handoff.
// Optional DFU_BOOT_TIMEOUT_EN adds a dfuIDLE inactivity timeout that forces detach and handoff.
module dfu_boot_ctrl
  import dfu_boot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 48000,
  parameter int unsigned SAMPLE_CYCLES   = 65536,
  parameter int unsigned DETACH_CYCLES   = 480000,
  parameter int unsigned TIMEOUT_CYCLES  = 480000000
) (
  input  logic            clk_48mhz,
  input  logic            reset,
  input  logic            pll_locked,
  input  logic            pwr_button,
  dfu_boot_ctrl_if.master dfu
);

  localparam int unsigned SD_MAX = (SAMPLE_CYCLES > DETACH_CYCLES) ? SAMPLE_CYCLES : DETACH_CYCLES;
`ifdef DFU_BOOT_TIMEOUT_EN
  localparam int unsigned CNT_MAX = (SD_MAX > TIMEOUT_CYCLES) ? SD_MAX : TIMEOUT_CYCLES;
`else
  localparam int unsigned CNT_MAX = SD_MAX;
`endif
  localparam int unsigned      CNT_W       = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DETACH_LAST = CNT_W'(DETACH_CYCLES - 1);

  if (SAMPLE_CYCLES < 2 || DETACH_CYCLES < 2 || TIMEOUT_CYCLES < 2 || DEBOUNCE_CYCLES < 1)
  begin : g_bad_params
    $error("dfu_boot_ctrl: cycle parameters out of range");
  end

  boot_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  boot_out_t        out_reg, out_next;
  logic [1:0]       lock_sync_reg;
  logic             btn_pressed;
  logic             manifest;
  logic             timeout_hit;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (1'b1)
  ) u_pwr_debounce (
    .clk_48mhz   (clk_48mhz),
    .reset       (reset),
    .btn_raw     (pwr_button),
    .btn_pressed (btn_pressed)
  );

  assign manifest = (dfu.dfu_state == DFU_ST_MANIFEST_WAIT_RST);

`ifdef DFU_BOOT_TIMEOUT_EN
  localparam int unsigned      TMO_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_reg, tmo_next;

  // Counts consecutive dfuIDLE cycles while in DFU; anything else restarts it.
  always_comb begin
    tmo_next    = '0;
    timeout_hit = 1'b0;
    if (state_reg == DFU && dfu.dfu_state == DFU_ST_IDLE) begin
      if (tmo_reg == TMO_LAST) begin
        timeout_hit = 1'b1;
      end else begin
        tmo_next = tmo_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      tmo_reg <= '0;
    end else begin
      tmo_reg <= tmo_next;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_reg     <= LOCK_WAIT;
      cnt_reg       <= '0;
      out_reg       <= BOOT_OUT_RESET;
      lock_sync_reg <= 2'b00;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      out_reg       <= out_next;
      lock_sync_reg <= {lock_sync_reg[0], pll_locked};
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    unique case (state_reg)
      LOCK_WAIT: begin
        if (lock_sync_reg[1]) state_next = SAMPLE;
      end
      SAMPLE: begin
        cnt_next = cnt_reg + 1'b1;
        // A press seen on the last window cycle still selects DFU.
        if (btn_pressed) begin
          state_next = DFU;
        end else if (cnt_reg == SAMPLE_LAST) begin
          state_next = HANDOFF;
        end
      end
      DFU: begin
        if (manifest || timeout_hit) state_next = DETACH;
      end
      DETACH: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == DETACH_LAST) state_next = HANDOFF;
      end
      HANDOFF: begin
        state_next = HANDOFF;
      end
      default: begin
        state_next = LOCK_WAIT;
      end
    endcase
    if (state_next != state_reg) cnt_next = '0;
  end

  // Outputs decode the current state and are registered, so they trail state entry by one cycle.
  always_comb begin
    out_next = BOOT_OUT_RESET;
    unique case (state_reg)
      SAMPLE: begin
        out_next.boot_mode = MODE_SAMPLE;
      end
      DFU: begin
        out_next.dfu_reset   = 1'b0;
        out_next.usb_pull_en = 1'b1;
        out_next.boot_mode   = MODE_DFU;
      end
      DETACH: begin
        out_next.dfu_reset = 1'b0;
        out_next.boot_mode = MODE_DFU;
      end
      HANDOFF: begin
        out_next.boot_req  = 1'b1;
        out_next.boot_mode = MODE_HANDOFF;
      end
      default: begin
        out_next = BOOT_OUT_RESET;
      end
    endcase
  end

  assign dfu.dfu_reset   = out_reg.dfu_reset;
  assign dfu.usb_pull_en = out_reg.usb_pull_en;
  assign dfu.boot_req    = out_reg.boot_req;
  assign dfu.boot_mode   = out_reg.boot_mode;

endmodule

// File: tb/tb_dfu_boot_ctrl.sv
// Randomised bench for dfu_boot_ctrl against a phase/timer reference model; DFU_BOOT_TIMEOUT_EN aware.
module tb_dfu_boot_ctrl;

  localparam int DEB = 4;
  localparam int SMP = 32;
  localparam int DET = 8;
  localparam int TMO = 64;

  localparam int PH_WAIT    = 0;
  localparam int PH_SAMPLE  = 1;
  localparam int PH_DFU     = 2;
  localparam int PH_DETACH  = 3;
  localparam int PH_HANDOFF = 4;

  logic clk_48mhz  = 1'b0;
  logic reset      = 1'b1;
  logic pll_locked = 1'b0;
  logic pwr_button = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cycle = 0;

  // Reference model: phase, time spent in phase, idle run, debounced button.
  int         m_phase = PH_WAIT;
  int         m_t     = 0;
  int         m_idle  = 0;
  int         m_run   = 0;
  bit         m_pressed = 1'b0;
  bit [1:0]   lock_hist = 2'b00;
  bit [1:0]   btn_hist  = 2'b00;
  logic [4:0] m_out   = 5'b00001;

  dfu_boot_ctrl_if dfu_if ();

  dfu_boot_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .SAMPLE_CYCLES   (SMP),
    .DETACH_CYCLES   (DET),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk_48mhz  (clk_48mhz),
    .reset      (reset),
    .pll_locked (pll_locked),
    .pwr_button (pwr_button),
    .dfu        (dfu_if.master)
  );

  always #10 clk_48mhz = ~clk_48mhz;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, n_cycle);
    end
  endtask

  // {boot_mode[1:0], boot_req, usb_pull_en, dfu_reset}
  function automatic logic [4:0] phase_outputs(input int ph);
    case (ph)
      PH_SAMPLE:  return 5'b01_0_0_1;
      PH_DFU:     return 5'b10_0_1_0;
      PH_DETACH:  return 5'b10_0_0_0;
      PH_HANDOFF: return 5'b11_1_0_1;
      default:    return 5'b00_0_0_1;
    endcase
  endfunction

  function automatic logic [4:0] dut_vec();
    return {dfu_if.boot_mode, dfu_if.boot_req, dfu_if.usb_pull_en, dfu_if.dfu_reset};
  endfunction

  task automatic enter(input int ph);
    m_phase = ph;
    m_t     = 0;
    m_idle  = 0;
  endtask

  task automatic model_edge();
    bit lock_s;
    bit lvl;
    bit pr;
    bit leave;
    lock_s = lock_hist[1];
    lvl    = btn_hist[1];
    pr     = m_pressed;
    leave  = 1'b0;
    if (reset) begin
      enter(PH_WAIT);
      m_pressed = 1'b0;
      m_run     = 0;
      lock_hist = 2'b00;
      btn_hist  = 2'b00;
      m_out     = phase_outputs(PH_WAIT);
      return;
    end
    m_out = phase_outputs(m_phase);
    case (m_phase)
      PH_WAIT: if (lock_s) enter(PH_SAMPLE);
      PH_SAMPLE: begin
        if (pr) enter(PH_DFU);
        else if (m_t == SMP - 1) enter(PH_HANDOFF);
        else m_t++;
      end
      PH_DFU: begin
        if (dfu_if.dfu_state == 8'h08) leave = 1'b1;
`ifdef DFU_BOOT_TIMEOUT_EN
        if (dfu_if.dfu_state == 8'h02) m_idle++;
        else m_idle = 0;
        if (m_idle == TMO) leave = 1'b1;
`endif
        if (leave) enter(PH_DETACH);
      end
      PH_DETACH: begin
        if (m_t == DET - 1) enter(PH_HANDOFF);
        else m_t++;
      end
      default: ;
    endcase
    if (lvl != m_pressed) begin
      m_run++;
      if (m_run == DEB) begin
        m_pressed = lvl;
        m_run     = 0;
      end
    end else begin
      m_run = 0;
    end
    lock_hist = {lock_hist[0], pll_locked};
    btn_hist  = {btn_hist[0], ~pwr_button};
  endtask

  task automatic tick();
    @(posedge clk_48mhz);
    model_edge();
    n_cycle++;
    @(negedge clk_48mhz);
    check_eq("cycle_outputs", dut_vec(), m_out);
  endtask

  task automatic wait_mode(input string tag, input logic [1:0] mode, input int budget, output int n);
    n = 0;
    while (n < budget && dfu_if.boot_mode !== mode) begin
      tick();
      n++;
    end
    check_eq(tag, dfu_if.boot_mode, mode);
  endtask

  task automatic do_reset();
    pwr_button       = 1'b1;
    pll_locked       = 1'b0;
    dfu_if.dfu_state = 8'h00;
    reset            = 1'b1;
    tick();
    check_eq("reset_outputs", dut_vec(), 5'b00_0_0_1);
    reset = 1'b0;
  endtask

  task automatic enter_dfu();
    int n;
    do_reset();
    pll_locked = 1'b1;
    repeat (6) tick();
    pwr_button = 1'b0;
    wait_mode("enter_dfu", 2'd2, 20, n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    int c;
    int ndet;
    logic [7:0] v;

    // 1: no press -> handoff after the full sample window
    do_reset();
    repeat ($urandom_range(0, 5)) tick();
    check_eq("s1_lockwait_mode", dfu_if.boot_mode, 2'd0);
    pll_locked = 1'b1;
    wait_mode("s1_handoff", 2'd3, 60, n);
    check_eq("s1_latency", n, 36);
    check_eq("s1_boot_req", dfu_if.boot_req, 1'b1);
    check_eq("s1_dfu_reset", dfu_if.dfu_reset, 1'b1);
    check_eq("s1_pull", dfu_if.usb_pull_en, 1'b0);
    $display("[TB] scenario no-press done, cycle %0d", n_cycle);

    // 2: press held mid-window
    do_reset();
    pll_locked = 1'b1;
    wait_mode("s2_sample", 2'd1, 10, n);
    repeat ($urandom_range(5, 15)) tick();
    pwr_button = 1'b0;
    wait_mode("s2_dfu", 2'd2, 20, n);
    check_eq("s2_latency", n, 8);
    check_eq("s2_dfu_reset", dfu_if.dfu_reset, 1'b0);
    check_eq("s2_pull", dfu_if.usb_pull_en, 1'b1);
    $display("[TB] scenario press done, cycle %0d", n_cycle);

    // press debounced exactly on the final window cycle wins; one cycle later loses
    do_reset();
    pll_locked = 1'b1;
    repeat (28) tick();
    pwr_button = 1'b0;
    wait_mode("sf_final_press_dfu", 2'd2, 20, n);
    check_eq("sf_latency", n, 8);
    do_reset();
    pll_locked = 1'b1;
    repeat (29) tick();
    pwr_button = 1'b0;
    wait_mode("sl_late_press_handoff", 2'd3, 20, n);
    check_eq("sl_latency", n, 7);
    $display("[TB] scenario window boundary done, cycle %0d", n_cycle);

    // 3: bounce shorter than the debounce time never registers
    do_reset();
    pll_locked = 1'b1;
    c = 0;
    while (c < 45) begin
      pwr_button = 1'b0;
      k = $urandom_range(1, 3);
      repeat (k) begin tick(); c++; end
      pwr_button = 1'b1;
      k = $urandom_range(1, 4);
      repeat (k) begin tick(); c++; end
    end
    check_eq("s3_mode", dfu_if.boot_mode, 2'd3);
    check_eq("s3_boot_req", dfu_if.boot_req, 1'b1);
    $display("[TB] scenario bounce done, cycle %0d", n_cycle);

    // 4: manifest -> detach for DET cycles -> handoff
    enter_dfu();
    k = $urandom_range(5, 20);
    repeat (k) begin
      v = 8'($urandom_range(0, 255));
      if (v == 8'h08) v = 8'h05;
      dfu_if.dfu_state = v;
      tick();
    end
    dfu_if.dfu_state = 8'h08;
    tick();
    check_eq("s4_pull_entry", dfu_if.usb_pull_en, 1'b1);
    ndet = 0;
    n = 0;
    while (n < 30 && dfu_if.boot_mode !== 2'd3) begin
      tick();
      n++;
      if (dfu_if.boot_mode === 2'd2 && dfu_if.usb_pull_en === 1'b0) ndet++;
    end
    check_eq("s4_detach_len", ndet, DET);
    check_eq("s4_mode", dfu_if.boot_mode, 2'd3);
    check_eq("s4_boot_req", dfu_if.boot_req, 1'b1);
    check_eq("s4_dfu_reset", dfu_if.dfu_reset, 1'b1);
    $display("[TB] scenario manifest done, cycle %0d", n_cycle);

    // 6a: reset while in HANDOFF
    reset = 1'b1;
    tick();
    check_eq("s6_handoff_boot_req", dfu_if.boot_req, 1'b0);
    check_eq("s6_handoff_dfu_reset", dfu_if.dfu_reset, 1'b1);
    check_eq("s6_handoff_mode", dfu_if.boot_mode, 2'd0);
    reset      = 1'b0;
    pll_locked = 1'b0;
    repeat (5) tick();
    check_eq("s6_lockwait_mode", dfu_if.boot_mode, 2'd0);

    // 5: idle timeout
`ifdef DFU_BOOT_TIMEOUT_EN
    enter_dfu();
    dfu_if.dfu_state = 8'h02;
    repeat (40) tick();
    check_eq("s5_idle40_pull", dfu_if.usb_pull_en, 1'b1);
    dfu_if.dfu_state = 8'h05;
    tick();
    dfu_if.dfu_state = 8'h02;
    n = 0;
    while (n < 100 && dfu_if.usb_pull_en === 1'b1) begin
      tick();
      n++;
    end
    check_eq("s5_timeout_latency", n, 65);
    check_eq("s5_detach_mode", dfu_if.boot_mode, 2'd2);
    // manifest on the same cycle the timeout expires
    enter_dfu();
    dfu_if.dfu_state = 8'h02;
    repeat (TMO - 1) tick();
    dfu_if.dfu_state = 8'h08;
    wait_mode("s5_both_handoff", 2'd3, 20, n);
    check_eq("s5_both_latency", n, 10);
`else
    enter_dfu();
    dfu_if.dfu_state = 8'h02;
    repeat (200) tick();
    check_eq("s5_no_timeout_mode", dfu_if.boot_mode, 2'd2);
    check_eq("s5_no_timeout_pull", dfu_if.usb_pull_en, 1'b1);
`endif
    $display("[TB] scenario idle timeout done, cycle %0d", n_cycle);

    // 6b: lock loss in DFU is ignored, then reset in DFU
    enter_dfu();
    pll_locked = 1'b0;
    repeat (20) tick();
    check_eq("s6_lockloss_mode", dfu_if.boot_mode, 2'd2);
    check_eq("s6_lockloss_pull", dfu_if.usb_pull_en, 1'b1);
    reset = 1'b1;
    tick();
    check_eq("s6_dfu_reset_vec", dut_vec(), 5'b00_0_0_1);
    reset = 1'b0;
    $display("[TB] scenario reset/lock-loss done, cycle %0d", n_cycle);

    // randomised soak against the model
    for (int it = 0; it < 24; it++) begin
      int lock_at;
      int press_mode;
      int press_at;
      int r;
      do_reset();
      lock_at    = $urandom_range(0, 6);
      press_mode = $urandom_range(0, 2);
      press_at   = $urandom_range(0, 40);
      for (int cyc = 0; cyc < 120; cyc++) begin
        if (cyc == lock_at) pll_locked = 1'b1;
        else if (cyc > lock_at + 5 && $urandom_range(0, 15) == 0) pll_locked = ~pll_locked;
        case (press_mode)
          0:       pwr_button = 1'b1;
          1:       pwr_button = (cyc >= press_at) ? 1'b0 : 1'b1;
          default: pwr_button = ($urandom_range(0, 2) != 0);
        endcase
        r = $urandom_range(0, 19);
        if (r < 14)       dfu_if.dfu_state = 8'h02;
        else if (r < 18)  dfu_if.dfu_state = 8'h05;
        else if (r == 18) dfu_if.dfu_state = 8'h08;
        else              dfu_if.dfu_state = 8'($urandom_range(0, 255));
        reset = ($urandom_range(0, 149) == 0);
        tick();
      end
      reset = 1'b0;
      $display("[TB] soak run %0d press_mode %0d final mode %0d, cycle %0d",
               it, press_mode, dfu_if.boot_mode, n_cycle);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
